// File: rtl/sobel_pkg.sv
// sobel_pkg: shared mode encodings and gradient width helper for the Sobel stream filter.
package sobel_pkg;

    typedef enum logic [1:0] {
        MODE_BIN = 2'd0,
        MODE_MAG = 2'd1,
        MODE_GX  = 2'd2,
        MODE_GY  = 2'd3
    } mode_e;

    function automatic int grad_w(input int pix_w);
        return pix_w + 3;
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// sobel_line_buffer: one-row circular RAM; read-before-write at a self-advancing pointer.
module sobel_line_buffer #(
    parameter int DEPTH = 224,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] ptr;

    assign rdata = mem[ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ptr <= '0;
        else if (en) ptr <= ptr == LAST ? '0 : ptr + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (en) mem[ptr] <= wdata;
    end

endmodule

// File: rtl/sobel_stream_filter.sv
// sobel_stream_filter: streaming 3x3 Sobel filter over a raster frame with valid/ready handshakes.
module sobel_stream_filter
    import sobel_pkg::*;
#(
    parameter int IMG_W = 224,
    parameter int IMG_H = 224,
    parameter int PIX_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [1:0]               mode,
    input  logic [grad_w(PIX_W)-1:0] thresh,
    input  logic [PIX_W-1:0]         in_pix,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [PIX_W-1:0]         out_pix,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done
);
    localparam int GW = grad_w(PIX_W);
    localparam int NIN = IMG_W * IMG_H;
    localparam int NOUT = (IMG_W - 2) * (IMG_H - 2);
    localparam int CW = $clog2(NIN + 1);
    localparam int OW = $clog2(NOUT + 1);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [CW-1:0] NIN_C = CW'(NIN);
    localparam logic [OW-1:0] OUT_LAST = OW'(NOUT - 1);
    localparam logic [XW-1:0] COL_LAST = XW'(IMG_W - 1);
    localparam logic [PIX_W-1:0] PMAX = '1;

    mode_e mode_r;
    logic [GW-1:0] thresh_r;
    logic [CW-1:0] in_cnt;
    logic [OW-1:0] out_cnt;
    logic [XW-1:0] col;
    logic [YW-1:0] row;
    logic [PIX_W-1:0] win [3][3];
    logic [PIX_W-1:0] lb0_q, lb1_q;
    logic wv, v1, advance, accept;
    logic signed [GW-1:0] gx_c, gy_c, gx_q, gy_q;
    logic [GW-1:0] ax, ay, a;
    logic [PIX_W-1:0] sel;

    function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] p);
        return signed'({{(GW - PIX_W){1'b0}}, p});
    endfunction

    function automatic logic [PIX_W-1:0] sat(input logic [GW-1:0] v);
        return |v[GW-1:PIX_W] ? PMAX : v[PIX_W-1:0];
    endfunction

    assign advance = !out_valid || out_ready;
    assign in_ready = busy && advance && (in_cnt < NIN_C);
    assign accept = in_valid && in_ready;

    // lb0 holds the previous row, lb1 the row before it
    sobel_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
        .clk(clk), .reset(reset), .en(accept), .wdata(in_pix), .rdata(lb0_q)
    );
    sobel_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
        .clk(clk), .reset(reset), .en(accept), .wdata(lb0_q), .rdata(lb1_q)
    );

    always_comb begin
        gx_c = ext(win[0][0]) + (ext(win[1][0]) <<< 1) + ext(win[2][0])
             - ext(win[0][2]) - (ext(win[1][2]) <<< 1) - ext(win[2][2]);
        gy_c = ext(win[0][0]) + (ext(win[0][1]) <<< 1) + ext(win[0][2])
             - ext(win[2][0]) - (ext(win[2][1]) <<< 1) - ext(win[2][2]);
        ax = gx_q[GW-1] ? -gx_q : gx_q;
        ay = gy_q[GW-1] ? -gy_q : gy_q;
        a = ax + ay;
        sel = mode_r == MODE_BIN ? (a >= thresh_r ? '0 : PMAX) :
              mode_r == MODE_MAG ? sat(a) :
              mode_r == MODE_GX  ? sat(ax) : sat(ay);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= 1'b0;
            done <= 1'b0;
            mode_r <= MODE_BIN;
            thresh_r <= '0;
            in_cnt <= '0;
            out_cnt <= '0;
            col <= '0;
            row <= '0;
            wv <= 1'b0;
            v1 <= 1'b0;
            gx_q <= '0;
            gy_q <= '0;
            out_valid <= 1'b0;
            out_pix <= '0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win[r][c] <= '0;
        end else begin
            done <= 1'b0;
            if (start && !busy && !done) begin
                busy <= 1'b1;
                mode_r <= mode_e'(mode);
                thresh_r <= thresh;
                in_cnt <= '0;
                out_cnt <= '0;
                col <= '0;
                row <= '0;
            end
            if (accept) begin
                in_cnt <= in_cnt + 1'b1;
                col <= col == COL_LAST ? '0 : col + 1'b1;
                row <= col == COL_LAST ? row + 1'b1 : row;
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                end
                win[0][2] <= lb1_q;
                win[1][2] <= lb0_q;
                win[2][2] <= in_pix;
            end
            // a window is complete once two full rows and two columns sit behind it
            if (advance) begin
                wv <= accept && row >= YW'(2) && col >= XW'(2);
                gx_q <= gx_c;
                gy_q <= gy_c;
                v1 <= wv;
                out_valid <= v1;
                if (v1) out_pix <= sel;
            end
            if (out_valid && out_ready) begin
                out_cnt <= out_cnt + 1'b1;
                if (out_cnt == OUT_LAST) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/sobel_stream_filter.md
SOBEL_STREAM_FILTER -- requirements
Module: sobel_stream_filter

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- IMG_W, 224, image width in pixels, 3..4096
- IMG_H, 224, image height in pixels, 3..4096
- PIX_W, 8, pixel width in bits
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk  in  1  single clock; all logic on posedge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a frame when idle
- mode  in  2  0 binary edge, 1 saturated magnitude, 2 abs Gx, 3 abs Gy
- thresh  in  PIX_W+3  binary-mode threshold
- in_pix  in  PIX_W  raster-order input pixel
- in_valid  in  1  in_pix valid
- in_ready  out  1  block accepts in_pix this cycle
- out_pix  out  PIX_W  filtered pixel
- out_valid  out  1  out_pix valid
- out_ready  in  1  sink accepts out_pix
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after last output accepted

Function
REQ-003 A frame starts when start=1 and busy=0; busy rises the next cycle, and start while busy=1 is ignored.
REQ-004 mode and thresh are sampled at frame start and held for the whole frame.
REQ-005 An input beat is accepted when in_valid=1, in_ready=1, and busy=1; in_ready is 0 whenever busy=0.
REQ-006 Input beats arrive in raster order, IMG_W*IMG_H beats per frame; input counters (col, row) wrap col at IMG_W-1 and advance row.
REQ-007 Two line buffers of depth IMG_W hold the previous two rows; a 3x3 window shift register is fed from the current pixel and both line-buffer outputs.
REQ-008 Output is produced only for interior centres (row 1..IMG_H-2, col 1..IMG_W-2), giving exactly (IMG_W-2)*(IMG_H-2) beats per frame in raster order; there is no padding.
REQ-009 Window p[r][c] (r,c in 0..2, r=0 oldest row): Gx = p00+2p10+p20-p02-2p12-p22 and Gy = p00+2p01+p02-p20-2p21-p22, signed, PIX_W+3 bits, no overflow.
REQ-010 A = |Gx|+|Gy|, unsigned, PIX_W+3 bits.
REQ-011 Output selection by mode:
- mode 0: out_pix = 0 if A >= thresh, else 2^PIX_W-1
- mode 1: out_pix = min(A, 2^PIX_W-1)
- mode 2: out_pix = min(|Gx|, 2^PIX_W-1)
- mode 3: out_pix = min(|Gy|, 2^PIX_W-1)
REQ-012 Pipeline has two registered stages (Gx/Gy, then A/select); out_valid for window centre (r,c) asserts 2 advancing cycles after acceptance of input pixel (r+1,c+1).
REQ-013 The whole pipeline advances only when advance = !out_valid || out_ready; in_ready = busy && advance && (input count < IMG_W*IMG_H).
REQ-014 out_pix and out_valid hold stable while out_valid=1 and out_ready=0.
REQ-015 done pulses for one cycle in the cycle after the final output beat is accepted; busy falls in that same cycle.
REQ-016 A start coincident with done is ignored; a new frame needs start with busy=0.

Reset
REQ-017 reset=1 asynchronously clears the following to 0: out_pix, out_valid, busy, done, in_ready, counters, and window registers. Line-buffer contents need not be cleared.
REQ-018 reset mid-frame abandons the frame; no done is produced, and the next frame needs a fresh start.

Structure
REQ-019 Shared package sobel_pkg holds mode encodings (MODE_BIN, MODE_MAG, MODE_GX, MODE_GY) and the gradient-width function PIX_W+3.
REQ-020 One sub-module, sobel_line_buffer: single-port-per-cycle circular RAM of depth IMG_W and width PIX_W, written and read under one enable, instantiated twice.

Verification
REQ-021 The bench covers these directed scenarios (IMG_W=8, IMG_H=5, out_ready=1 unless stated):
- Constant 100 image, mode 0, thresh 200: 18 beats, all 255; done one cycle after the last beat.
- Vertical step, cols 0..3=0 and cols 4..7=255, mode 1: cols 3,4 of each output row = 255, others 0; mode 2 gives the same values, mode 3 gives all 0.
- Same step, mode 0, thresh 1021: all outputs 255; thresh 1020: cols 3,4 = 0.
- Step image with out_ready random at 50%: output sequence identical to the out_ready=1 run, and out_pix never changes while stalled.
- reset asserted after 20 input beats: all outputs 0 at once, no done; a new start then yields a correct 18-beat frame.
- start pulsed mid-frame: ignored, beat count still 18; a start on the done cycle produces no new frame.
